// File: rtl/and_col_pkg.sv
// Shared definitions for the AND result collector: FSM state encoding,
// default sizing constants and the even-parity helper.
package and_col_pkg;

    localparam int ANDCOL_WIDTH = 8;
    localparam int ANDCOL_CNTW  = 16;

    typedef logic [0:0] andcol_state_t;
    localparam andcol_state_t ST_IDLE = 1'b0;
    localparam andcol_state_t ST_ACC  = 1'b1;

    // XOR of all bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/andcol_shifter.sv
// Serial-to-parallel shifter with bit counter; strobes done_o for the single
// cycle whose inen edge samples the last bit of a word.
module andcol_shifter
    import and_col_pkg::*;
#(
    parameter int WIDTH = ANDCOL_WIDTH
) (
    input  logic             inclk,
    input  logic             inrst,
    input  logic             inbit,
    input  logic             inen,
    output logic [WIDTH-1:0] word_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    andcol_state_t       state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-2:0]    sr_q, sr_d;

    // Next-state, shift and completion decode; the newest bit enters the LSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        done_o  = 1'b0;
        word_o  = {sr_q, inbit};
        if (inen) begin
            sr_d = word_o[WIDTH-2:0];
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = CW'(1);
                    state_d = ST_ACC;
                end
                ST_ACC: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        done_o  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            done_o = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge inclk or posedge inrst) begin
        if (inrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

endmodule

// File: rtl/and_result_collector.sv
// Packs AND-stage result bits into WIDTH-bit words with a valid/ready output,
// transfer counter and sticky overflow. Optional parity: define ANDCOL_PARITY_EN.
module and_result_collector
    import and_col_pkg::*;
#(
    parameter int WIDTH = ANDCOL_WIDTH,
    parameter int CNTW  = ANDCOL_CNTW
) (
    input  logic             inclk,
    input  logic             inrst,
    input  logic             inbit,
    input  logic             inen,
    output logic [WIDTH-1:0] outdata,
    output logic             outvalid,
    input  logic             inready,
    output logic [CNTW-1:0]  outcount,
    output logic             outovf,
    output logic             outpar
);

    logic [WIDTH-1:0] word_s;
    logic             done_s;
    logic             xfer_s;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d;

    andcol_shifter #(.WIDTH(WIDTH)) u_shifter (
        .inclk  (inclk),
        .inrst  (inrst),
        .inbit  (inbit),
        .inen   (inen),
        .word_o (word_s),
        .done_o (done_s)
    );

    assign xfer_s = valid_q & inready;

    // Output holding register: a completed word loads only if the slot is free
    // or drains on this same edge, otherwise it is dropped and flagged.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = xfer_s ? count_q + CNTW'(1) : count_q;
        ovf_d   = ovf_q;
        if (done_s) begin
            if (!valid_q || inready) begin
                data_d  = word_s;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output, counter and overflow registers.
    always_ff @(posedge inclk or posedge inrst) begin
        if (inrst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign outdata  = data_q;
    assign outvalid = valid_q;
    assign outcount = count_q;
    assign outovf   = ovf_q;

`ifdef ANDCOL_PARITY_EN
    logic par_q;

    // Parity registered alongside the data it covers.
    always_ff @(posedge inclk or posedge inrst) begin
        if (inrst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= even_parity(32'(data_d));
        end
    end

    assign outpar = par_q;
`else
    assign outpar = 1'b0;
`endif

endmodule

// File: tb/tb_and_result_collector.sv
// Directed self-checking bench for and_result_collector (WIDTH=8, CNTW=16).
module tb_and_result_collector;

    logic        inclk;
    logic        inrst;
    logic        inbit;
    logic        inen;
    logic        inready;
    logic [7:0]  outdata;
    logic        outvalid;
    logic [15:0] outcount;
    logic        outovf;
    logic        outpar;

    int n_cmp = 0;
    int n_err = 0;

    and_result_collector #(.WIDTH(8), .CNTW(16)) dut (
        .inclk    (inclk),
        .inrst    (inrst),
        .inbit    (inbit),
        .inen     (inen),
        .outdata  (outdata),
        .outvalid (outvalid),
        .inready  (inready),
        .outcount (outcount),
        .outovf   (outovf),
        .outpar   (outpar)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    function automatic logic exp_par(input logic [7:0] d);
`ifdef ANDCOL_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then let one rising edge pass and settle 1 time unit.
    task automatic tick(input logic b, input logic en, input logic rdy);
        inbit   = b;
        inen    = en;
        inready = rdy;
        @(posedge inclk);
        #1;
    endtask

    // Send the first 7 bits of a word MSB first; caller sends the last bit.
    task automatic send7(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 1; i--) tick(w[i], 1'b1, rdy);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                           input logic [15:0] c, input logic o);
        chk({tag, "_data"},  32'(outdata),  32'(d));
        chk({tag, "_valid"}, 32'(outvalid), 32'(v));
        chk({tag, "_count"}, 32'(outcount), 32'(c));
        chk({tag, "_ovf"},   32'(outovf),   32'(o));
        chk({tag, "_par"},   32'(outpar),   32'(exp_par(d)));
    endtask

    initial begin
        inrst = 1'b1; inbit = 1'b0; inen = 1'b0; inready = 1'b0;
        #1;
        chk_out("reset", 8'h00, 1'b0, 16'd0, 1'b0);
        @(posedge inclk);
        #1 inrst = 1'b0;

        // Sweep 0,0,0,1,0,0,0,1 with ready high.
        send7(8'h11, 1'b1);
        chk("sweep_early_valid", 32'(outvalid), 32'd0);
        tick(1'b1, 1'b1, 1'b1);
        chk_out("sweep_word", 8'h11, 1'b1, 16'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk_out("sweep_xfer", 8'h11, 1'b0, 16'd1, 1'b0);

        // Same word with idle cycles between bits.
        for (int i = 7; i >= 1; i--) begin
            tick(1'b1, 1'b0, 1'b1);
            tick(8'h11 >> i, 1'b1, 1'b1);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("gap_early_valid", 32'(outvalid), 32'd0);
        tick(1'b1, 1'b1, 1'b1);
        chk_out("gap_word", 8'h11, 1'b1, 16'd1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk_out("gap_xfer", 8'h11, 1'b0, 16'd2, 1'b0);

        // Backpressure: 8 ones with ready low, hold 5 cycles, then accept.
        send7(8'hFF, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk_out("bp_word", 8'hFF, 1'b1, 16'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("bp_hold_valid", 32'(outvalid), 32'd1);
            chk("bp_hold_data",  32'(outdata),  32'hFF);
        end
        tick(1'b0, 1'b0, 1'b1);
        chk_out("bp_xfer", 8'hFF, 1'b0, 16'd3, 1'b0);

        // Overflow: A5 then 3C back to back with ready low.
        send7(8'hA5, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk_out("ovf_first", 8'hA5, 1'b1, 16'd3, 1'b0);
        send7(8'h3C, 1'b0);
        chk("ovf_15th", 32'(outovf), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        chk_out("ovf_16th", 8'hA5, 1'b1, 16'd3, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk_out("ovf_drain", 8'hA5, 1'b0, 16'd4, 1'b1);

        // Simultaneous: word 07 completes on the edge that transfers 5A.
        send7(8'h5A, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk_out("sim_w1", 8'h5A, 1'b1, 16'd4, 1'b1);
        send7(8'h07, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        chk_out("sim_w2", 8'h07, 1'b1, 16'd5, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk_out("sim_drain", 8'h07, 1'b0, 16'd6, 1'b1);

        // Reset after 3 bits of a word; pulse lands between clock edges.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        inen = 1'b0;
        #1 inrst = 1'b1;
        #1;
        chk_out("rst_mid", 8'h00, 1'b0, 16'd0, 1'b0);
        #1 inrst = 1'b0;
        send7(8'hC3, 1'b1);
        chk("rst_fresh_early", 32'(outvalid), 32'd0);
        tick(1'b1, 1'b1, 1'b1);
        chk_out("rst_fresh_word", 8'hC3, 1'b1, 16'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        chk_out("rst_fresh_xfer", 8'hC3, 1'b0, 16'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/and_result_collector.md
AND_RESULT_COLLECTOR -- requirements
Module: and_result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of result bits packed per output word (legal range 2..32).
REQ-002 The block SHALL have parameter CNTW, default 16, giving the width of the completed-word counter.
REQ-003 The block SHALL have port inclk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port inrst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port inbit, input, 1 bit, the result bit from the upstream AND stage (its outy).
REQ-006 The block SHALL have port inen, input, 1 bit, qualifying inbit; when high, inbit is sampled this edge.
REQ-007 The block SHALL have port outdata, output, WIDTH bits, the packed word.
REQ-008 The block SHALL have port outvalid, output, 1 bit, high while outdata holds an untaken word.
REQ-009 The block SHALL have port inready, input, 1 bit, consumer accept; a transfer occurs on an edge with outvalid=1 and inready=1.
REQ-010 The block SHALL have port outcount, output, CNTW bits, the number of words transferred (wraps modulo 2^CNTW).
REQ-011 The block SHALL have port outovf, output, 1 bit, sticky overflow flag.
REQ-012 The block SHALL have port outpar, output, 1 bit, even-parity bit of outdata.

Function
REQ-013 Shift-side FSM SHALL have states IDLE (0 bits held) and ACC (1..WIDTH-1 bits held).
- IDLE -> ACC on an inen=1 edge (WIDTH>1).
- ACC -> IDLE on the edge sampling the WIDTH-th bit.
REQ-014 Each inen=1 edge SHALL shift inbit into the LSB of the shift register (shift left); the first sampled bit ends in outdata MSB.
REQ-015 On the edge sampling the WIDTH-th bit, the completed word SHALL load into outdata and outvalid SHALL be set, visible the cycle after that edge (latency 1 edge).
REQ-016 An edge with inen=0 SHALL leave the shift register and bit count unchanged, with no timeout.
REQ-017 Outvalid SHALL stay high and outdata SHALL stay stable until a transfer occurs.
REQ-018 On a transfer edge, outvalid SHALL clear and outcount SHALL increment by 1, unless a new word completes on the same edge; in that case the new word loads and outvalid stays 1.
REQ-019 If a word completes on an edge with outvalid=1 and inready=0, the new word SHALL be discarded, outdata SHALL be kept, and outovf SHALL set and remain 1 until reset.
REQ-020 Bit accumulation SHALL continue unaffected by output stalls.
REQ-021 Outcount SHALL wrap from 2^CNTW-1 to 0 without flagging.

Reset
REQ-022 On inrst=1, immediately and independent of inclk, the block SHALL apply:
- FSM to IDLE, bit count 0, shift register 0;
- outdata 0, outvalid 0, outcount 0, outovf 0, outpar 0.
REQ-023 Reset asserted mid-word SHALL discard the partial word and any pending output word.
REQ-024 After inrst deasserts, the first inen=1 edge SHALL be treated as bit 1 of a new word.

Configuration
REQ-025 When macro ANDCOL_PARITY_EN is defined, outpar SHALL equal the XOR of all outdata bits, registered together with outdata.
REQ-026 When ANDCOL_PARITY_EN is undefined, outpar SHALL be constant 0 and no parity logic SHALL be built; the port list is unchanged.

Structure
REQ-027 A shared package and_col_pkg SHALL hold:
- the FSM state typedef (IDLE, ACC);
- default constants ANDCOL_WIDTH=8 and ANDCOL_CNTW=16.
REQ-028 The design SHALL contain one sub-module, andcol_shifter: shift register plus bit counter, emitting a word plus a one-cycle word-complete strobe.
REQ-029 The output register, handshake, counter and overflow logic SHALL reside in the top module.

Verification
REQ-030 The bench SHALL cover the upstream sweep:
- stimulus: inbit pattern 0,0,0,1,0,0,0,1 with inen=1 and inready=1;
- response: outdata=8'h11 and outvalid=1 for one cycle, outcount=1, outpar=0 with macro defined.
REQ-031 The bench SHALL cover gaps:
- stimulus: the same 8 bits with inen=0 cycles interleaved;
- response: identical outdata=8'h11, no early outvalid.
REQ-032 The bench SHALL cover backpressure:
- stimulus: inready=0, then 8 ones, then a 5-cycle hold, then inready=1;
- response: outdata=8'hFF stable with outvalid=1 throughout; transfer on the first ready edge; outcount=1.
REQ-033 The bench SHALL cover overflow:
- stimulus: inready=0 with 16 consecutive bits, the first word 8'hA5 and the second 8'h3C;
- response: outdata stays 8'hA5; outovf=1 from the 16th edge on; outcount unchanged.
REQ-034 The bench SHALL cover simultaneous events:
- stimulus: word 2 completes on the same edge that word 1 transfers;
- response: outvalid stays 1, outdata shows word 2, outcount increments once.
REQ-035 The bench SHALL cover reset mid-word:
- stimulus: inrst pulse after 3 bits;
- response: all outputs 0 immediately; the next 8 bits form a fresh word.
